// File: rtl/fwd_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fwd_pkg
// Shared types and helpers for the forwarding / load-use hazard controller.
//   fwd_entry_t : one tracker slot {valid, rd, wr, is_load}
//   FWD_SEL_RF  : forward-select code meaning "read the register file"
//   clog2       : ceiling log2, used to size the forward-select fields
// Tracker entries carry rd at a fixed width of RD_MAX_W bits so the struct can
// live in a package; register indices narrower than that are zero-extended.
// ----------------------------------------------------------------------------
package fwd_pkg;

   localparam int RD_MAX_W   = 16;
   localparam int FWD_SEL_RF = 0;

   typedef struct packed {
      logic                valid;
      logic [RD_MAX_W-1:0] rd;
      logic                wr;
      logic                is_load;
   } fwd_entry_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Bundle between the ID stage / pipeline control and the hazard controller.
//   id_valid, id_rs, id_rs_used, id_rd, id_rd_wr, id_is_load : ID instruction
//   ext_stall : global freeze,  flush : kill EX slot and this cycle's issue
//   stall     : load-use stall back to ID/IF
//   fwd_sel   : per-source EX operand mux selects (SEL_W bits each)
//   ex_valid  : EX slot holds a live instruction
//   stall_cnt : saturating load-use stall cycle counter
// master = pipeline control side, slave = hazard controller.
// ----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if
   import fwd_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int NUM_SRC   = 2,
   parameter int FWD_DEPTH = 2
);

   localparam int SEL_W = clog2(FWD_DEPTH + 1);

   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic [REG_AW-1:0]         id_rd;
   logic                      id_rd_wr;
   logic                      id_is_load;
   logic                      ext_stall;
   logic                      flush;
   logic                      stall;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic                      ex_valid;
   logic [31:0]               stall_cnt;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rd, id_rd_wr, id_is_load,
      output ext_stall, flush,
      input  stall, fwd_sel, ex_valid, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rd, id_rd_wr, id_is_load,
      input  ext_stall, flush,
      output stall, fwd_sel, ex_valid, stall_cnt
   );

endinterface

// File: rtl/fwd_hazard_ctrl_src_match.sv
// ----------------------------------------------------------------------------
// fwd_src_match
// Combinational priority encoder for one source operand.
//   rs, used : source index and "operand actually read" flag
//   slots    : tracker contents, slot 0 = EX
//   sel      : winning stage (j+1) or FWD_SEL_RF when nothing matches
//   hit      : some in-flight producer matches
//   load_haz : winning producer is a load whose data is not ready in time
// ----------------------------------------------------------------------------
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 2,
   parameter int LOAD_RDY  = 2,
   parameter int SEL_W     = 2
)
(
   input  logic                       rs_unused_guard,
   input  logic [REG_AW-1:0]          rs,
   input  logic                       used,
   input  fwd_entry_t [FWD_DEPTH-1:0] slots,
   output logic [SEL_W-1:0]           sel,
   output logic                       hit,
   output logic                       load_haz
);

   logic [RD_MAX_W-1:0] rs_ext;

   assign rs_ext = RD_MAX_W'(rs);

   // Scan from oldest to youngest so the smallest matching slot is written
   // last and therefore wins. x0 is hard-wired zero and never forwards.
   always_comb begin
      sel      = SEL_W'(FWD_SEL_RF);
      hit      = 1'b0;
      load_haz = 1'b0;
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
         if (used && rs_unused_guard && (rs_ext != '0) && slots[j].valid &&
             slots[j].wr && (slots[j].rd == rs_ext)) begin
            sel      = SEL_W'(j + 1);
            hit      = 1'b1;
            load_haz = slots[j].is_load && ((j + 1) < LOAD_RDY);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller beside the ID/EX register.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : fwd_hazard_ctrl_if slave (ID request in, stall/fwd_sel/
//              ex_valid/stall_cnt out)
// A shift register of FWD_DEPTH slots tracks in-flight destinations from EX
// onward; selects for the instruction in ID are registered so they line up
// with the ID/EX register outputs. The interface instance must be built with
// the same REG_AW, NUM_SRC and FWD_DEPTH as this module.
// ----------------------------------------------------------------------------
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int NUM_SRC   = 2,
   parameter int FWD_DEPTH = 2,
   parameter int LOAD_RDY  = 2
)
(
   input logic              clk,
   input logic              rst,
   fwd_hazard_ctrl_if.slave bus
);

   localparam int SEL_W = clog2(FWD_DEPTH + 1);
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   fwd_entry_t [FWD_DEPTH-1:0] slots;
   fwd_entry_t                 id_entry;
   logic [SEL_W-1:0]           src_sel [NUM_SRC];
   logic [NUM_SRC-1:0]         src_hit;
   logic [NUM_SRC-1:0]         src_load_haz;
   logic [NUM_SRC*SEL_W-1:0]   sel_calc;
   logic [NUM_SRC*SEL_W-1:0]   fwd_sel_q;
   logic                       ex_valid_q;
   logic [31:0]                stall_cnt_q;
   logic                       stall;
   logic                       issue;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_src_match #(
         .REG_AW    (REG_AW),
         .FWD_DEPTH (FWD_DEPTH),
         .LOAD_RDY  (LOAD_RDY),
         .SEL_W     (SEL_W)
      ) u_match (
         .rs_unused_guard (1'b1),
         .rs              (bus.id_rs[g*REG_AW +: REG_AW]),
         .used            (bus.id_rs_used[g]),
         .slots           (slots),
         .sel             (src_sel[g]),
         .hit             (src_hit[g]),
         .load_haz        (src_load_haz[g])
      );
   end

   // Pack the per-source winners into the flat select vector.
   always_comb begin
      sel_calc = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sel_calc[i*SEL_W +: SEL_W] = src_hit[i] ? src_sel[i] : SEL_W'(FWD_SEL_RF);
      end
   end

   // Stall is not gated by ext_stall so ID sees a stable request during a
   // freeze; issue is, because nothing may move while frozen.
   assign stall = bus.id_valid & ~bus.flush & (|src_load_haz);
   assign issue = bus.id_valid & ~stall & ~bus.flush & ~bus.ext_stall;

   // Tracker entry describing the instruction currently in ID.
   always_comb begin
      id_entry         = '0;
      id_entry.valid   = 1'b1;
      id_entry.rd      = RD_MAX_W'(bus.id_rd);
      id_entry.wr      = bus.id_rd_wr;
      id_entry.is_load = bus.id_is_load;
   end

   // Tracker shift and EX-aligned outputs. A flush drops the EX entry on its
   // way into slot 1 so the killed instruction never appears as a producer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots      <= '0;
         fwd_sel_q  <= '0;
         ex_valid_q <= 1'b0;
      end else if (!bus.ext_stall) begin
         slots[0] <= issue ? id_entry : fwd_entry_t'('0);
         for (int j = 1; j < FWD_DEPTH; j++) begin
            slots[j] <= ((j == 1) && bus.flush) ? fwd_entry_t'('0) : slots[j-1];
         end
         fwd_sel_q  <= issue ? sel_calc : '0;
         ex_valid_q <= issue;
      end
   end

   // Saturating count of cycles actually lost to load-use stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (stall && !bus.ext_stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall     = stall;
   assign bus.fwd_sel   = fwd_sel_q;
   assign bus.ex_valid  = ex_valid_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Directed bench for fwd_hazard_ctrl. Two instances share one stimulus:
//   dut_a : FWD_DEPTH=2, LOAD_RDY=2 (default pipeline)
//   dut_b : FWD_DEPTH=3, LOAD_RDY=1 (deeper forwarding, loads ready at EX/MEM)
// Inputs change on the falling edge; each applyStimulus returns 1 time unit
// later, when registered outputs reflect the previous vector and stall
// reflects the current one.
// ----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   fwd_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2)) bus_a ();
   fwd_hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3)) bus_b ();

   fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_RDY(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_RDY(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   // Drive one ID vector into both instances on the falling edge.
   task automatic applyStimulus(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [1:0] used, input logic [4:0] rd, input logic wr,
                                input logic ld, input logic ext, input logic fl);
      @(negedge clk);
      bus_a.id_valid   = v;
      bus_a.id_rs      = {rs1, rs0};
      bus_a.id_rs_used = used;
      bus_a.id_rd      = rd;
      bus_a.id_rd_wr   = wr;
      bus_a.id_is_load = ld;
      bus_a.ext_stall  = ext;
      bus_a.flush      = fl;
      bus_b.id_valid   = v;
      bus_b.id_rs      = {rs1, rs0};
      bus_b.id_rs_used = used;
      bus_b.id_rd      = rd;
      bus_b.id_rd_wr   = wr;
      bus_b.id_is_load = ld;
      bus_b.ext_stall  = ext;
      bus_b.flush      = fl;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.id_valid = 1'b0; bus_a.id_rs = '0; bus_a.id_rs_used = '0; bus_a.id_rd = '0;
      bus_a.id_rd_wr = 1'b0; bus_a.id_is_load = 1'b0; bus_a.ext_stall = 1'b0; bus_a.flush = 1'b0;
      bus_b.id_valid = 1'b0; bus_b.id_rs = '0; bus_b.id_rs_used = '0; bus_b.id_rd = '0;
      bus_b.id_rd_wr = 1'b0; bus_b.id_is_load = 1'b0; bus_b.ext_stall = 1'b0; bus_b.flush = 1'b0;
      #7;
      checkOutput("rst_a_sel",   bus_a.fwd_sel,   0);
      checkOutput("rst_a_exv",   bus_a.ex_valid,  0);
      checkOutput("rst_a_cnt",   bus_a.stall_cnt, 0);
      checkOutput("rst_a_stall", bus_a.stall,     0);
      checkOutput("rst_b_sel",   bus_b.fwd_sel,   0);
      checkOutput("rst_b_exv",   bus_b.ex_valid,  0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] back-to-back ALU dependency");
      applyStimulus(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 0, 0);
      checkOutput("alu1_stall", bus_a.stall, 0);
      applyStimulus(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0, 0);
      checkOutput("alu1_sel", bus_a.fwd_sel, 0);
      checkOutput("alu1_exv", bus_a.ex_valid, 1);
      checkOutput("alu2_stall", bus_a.stall, 0);
      applyStimulus(1, 5'd5, 5'd0, 2'b11, 5'd7, 1, 0, 0, 0);
      checkOutput("alu2_sel", bus_a.fwd_sel, 4'b0101);
      applyStimulus(1, 5'd5, 5'd0, 2'b11, 5'd8, 1, 0, 0, 0);
      checkOutput("alu3_sel", bus_a.fwd_sel, 4'b0010);
      idle();
      checkOutput("alu4_sel", bus_a.fwd_sel, 0);
      checkOutput("alu4_exv", bus_a.ex_valid, 1);

      $display("[TB] load-use stall");
      applyStimulus(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0);
      checkOutput("lu_idle_exv", bus_a.ex_valid, 0);
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd9, 1, 0, 0, 0);
      checkOutput("lu_stall", bus_a.stall, 1);
      checkOutput("lu_lw_exv", bus_a.ex_valid, 1);
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd9, 1, 0, 0, 0);
      checkOutput("lu_release", bus_a.stall, 0);
      checkOutput("lu_bubble_exv", bus_a.ex_valid, 0);
      checkOutput("lu_cnt", bus_a.stall_cnt, 1);
      idle();
      checkOutput("lu_sel", bus_a.fwd_sel, 4'b0010);
      checkOutput("lu_exv", bus_a.ex_valid, 1);

      $display("[TB] x0 and unused sources");
      applyStimulus(1, 5'd1, 5'd1, 2'b11, 5'd0, 1, 0, 0, 0);
      applyStimulus(1, 5'd0, 5'd0, 2'b11, 5'd10, 1, 0, 0, 0);
      checkOutput("x0_stall", bus_a.stall, 0);
      applyStimulus(1, 5'd1, 5'd0, 2'b01, 5'd12, 1, 1, 0, 0);
      checkOutput("x0_sel", bus_a.fwd_sel, 0);
      applyStimulus(1, 5'd1, 5'd12, 2'b01, 5'd13, 1, 0, 0, 0);
      checkOutput("unused_stall", bus_a.stall, 0);
      idle();
      checkOutput("unused_sel", bus_a.fwd_sel, 0);
      checkOutput("unused_cnt", bus_a.stall_cnt, 1);

      $display("[TB] youngest producer wins");
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd3, 1, 0, 0, 0);
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd3, 1, 0, 0, 0);
      applyStimulus(1, 5'd3, 5'd3, 2'b11, 5'd14, 1, 0, 0, 0);
      idle();
      checkOutput("young_sel", bus_a.fwd_sel, 4'b0101);

      $display("[TB] flush of a load in EX");
      applyStimulus(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0);
      checkOutput("fl_idle_exv", bus_a.ex_valid, 0);
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd15, 1, 0, 0, 1);
      checkOutput("fl_stall", bus_a.stall, 0);
      checkOutput("fl_lw_exv", bus_a.ex_valid, 1);
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd15, 1, 0, 0, 0);
      checkOutput("fl_after_stall", bus_a.stall, 0);
      checkOutput("fl_killed_exv", bus_a.ex_valid, 0);
      idle();
      checkOutput("fl_sel", bus_a.fwd_sel, 0);
      checkOutput("fl_exv", bus_a.ex_valid, 1);
      checkOutput("fl_cnt", bus_a.stall_cnt, 1);

      $display("[TB] ext_stall during load-use stall");
      applyStimulus(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd16, 1, 0, 1, 0);
         checkOutput("frz_stall", bus_a.stall, 1);
         checkOutput("frz_exv", bus_a.ex_valid, 1);
         checkOutput("frz_sel", bus_a.fwd_sel, 0);
         checkOutput("frz_cnt", bus_a.stall_cnt, 1);
      end
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd16, 1, 0, 0, 0);
      checkOutput("thaw_stall", bus_a.stall, 1);
      checkOutput("thaw_exv", bus_a.ex_valid, 1);
      checkOutput("thaw_cnt", bus_a.stall_cnt, 1);
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd16, 1, 0, 0, 0);
      checkOutput("thaw_release", bus_a.stall, 0);
      checkOutput("thaw_bubble_exv", bus_a.ex_valid, 0);
      checkOutput("thaw_cnt2", bus_a.stall_cnt, 2);
      idle();
      checkOutput("thaw_sel", bus_a.fwd_sel, 4'b0010);
      checkOutput("thaw_exv2", bus_a.ex_valid, 1);

      $display("[TB] asynchronous reset mid-stream");
      applyStimulus(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0);
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd17, 1, 0, 0, 0);
      checkOutput("pre_rst_stall", bus_a.stall, 1);
      checkOutput("pre_rst_exv", bus_a.ex_valid, 1);
      rst = 1'b1;
      #1;
      checkOutput("arst_stall", bus_a.stall, 0);
      checkOutput("arst_exv", bus_a.ex_valid, 0);
      checkOutput("arst_sel", bus_a.fwd_sel, 0);
      checkOutput("arst_cnt", bus_a.stall_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd17, 1, 0, 0, 0);
      checkOutput("post_rst_stall", bus_a.stall, 0);
      idle();
      checkOutput("post_rst_sel", bus_a.fwd_sel, 0);
      checkOutput("post_rst_exv", bus_a.ex_valid, 1);

      $display("[TB] deeper tracker, loads ready at EX/MEM");
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd3, 1, 0, 0, 0);
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd3, 1, 0, 0, 0);
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd3, 1, 0, 0, 0);
      applyStimulus(1, 5'd3, 5'd3, 2'b11, 5'd18, 1, 0, 0, 0);
      idle();
      checkOutput("b_young3_sel", bus_b.fwd_sel, 4'b0101);
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd3, 1, 0, 0, 0);
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd20, 1, 0, 0, 0);
      applyStimulus(1, 5'd1, 5'd1, 2'b00, 5'd21, 1, 0, 0, 0);
      applyStimulus(1, 5'd3, 5'd0, 2'b01, 5'd22, 1, 0, 0, 0);
      idle();
      checkOutput("b_slot2_sel", bus_b.fwd_sel, 4'b0011);
      applyStimulus(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0);
      applyStimulus(1, 5'd7, 5'd0, 2'b01, 5'd23, 1, 0, 0, 0);
      checkOutput("b_ld_stall", bus_b.stall, 0);
      idle();
      checkOutput("b_ld_sel", bus_b.fwd_sel, 4'b0001);
      checkOutput("b_ld_exv", bus_b.ex_valid, 1);
      checkOutput("b_ld_cnt", bus_b.stall_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
